// File: rtl/alu_mc_if.sv
// Opcode package and handshake interface for the multi-cycle ALU.
//   master: issues ops (in_valid_i, op_i, operand_a_i, operand_b_i) and takes
//           results (out_ready_i); sees in_ready_o, out_valid_o, result_o, err_o.
//   slave : the ALU side of the same signals.
package nyakuo_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDI, OP_SUB,
    OP_SLL, OP_SLLI, OP_SRL, OP_SRLI, OP_SRA, OP_SRAI,
    OP_XOR, OP_XORI, OP_OR, OP_ORI, OP_AND, OP_ANDI,
    OP_SLT, OP_SLTI, OP_SLTU, OP_SLTIU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MUL
  } instruction;

endpackage

interface alu_mc_if #(
  parameter int unsigned XLEN = 32
) ();
  import nyakuo_pkg::*;

  logic            in_valid_i;
  logic            in_ready_o;
  instruction      op_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            err_o;

  modport master (
    output in_valid_i, op_i, operand_a_i, operand_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, err_o
  );

  modport slave (
    input  in_valid_i, op_i, operand_a_i, operand_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, err_o
  );

endinterface

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle add/sub/shift/logic/compare ops and an
// iterative restoring divider (DIV/DIVU/REM/REMU) retiring DIV_RADIX_W quotient
// bits per cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : kills an in-flight divide and any pending result
//   bus (slave)   : valid/ready op input, valid/ready registered result + err
module alu_mc
  import nyakuo_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DIV_RADIX_W = 1
) (
  input logic    clk_i,
  input logic    rst_ni,
  input logic    flush_i,
  alu_mc_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned DIV_CYC = XLEN / DIV_RADIX_W;
  localparam int unsigned CNT_W   = $clog2(DIV_CYC);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // DIV_WAIT parks a finished quotient/remainder while the output is occupied.
  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DIV_WAIT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a, b, a_abs, b_abs;
  logic [SHAMT_W-1:0] shamt;
  logic              is_div, div_signed, div_rem, div_special;
  logic [XLEN-1:0]   fast_res;
  logic              fast_err;
  logic              out_free, in_ready_c, accept, load_fast, div_start, div_done;
  logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quo_q, neg_rem_q, is_rem_q;
  logic [XLEN:0]     rem_ext;
  logic [XLEN-1:0]   step_quo, step_rem, fin_quo, fin_rem, div_res;
  logic              out_valid_q, err_q;
  logic [XLEN-1:0]   result_q;

  assign a     = bus.operand_a_i;
  assign b     = bus.operand_b_i;
  assign shamt = b[SHAMT_W-1:0];

  // Divide decode and the cases that finish without iterating.
  always_comb begin
    is_div     = 1'b0;
    div_signed = 1'b0;
    div_rem    = 1'b0;
    case (bus.op_i)
      OP_DIV:  begin is_div = 1'b1; div_signed = 1'b1; end
      OP_DIVU: begin is_div = 1'b1; end
      OP_REM:  begin is_div = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
      OP_REMU: begin is_div = 1'b1; div_rem = 1'b1; end
      default: ;
    endcase
    div_special = is_div & ((b == '0) | (div_signed & (a == MIN_INT) & (b == '1)));
    a_abs = (div_signed & a[XLEN-1]) ? -a : a;
    b_abs = (div_signed & b[XLEN-1]) ? -b : b;
  end

  // Latency-1 results, including the divide special cases.
  always_comb begin
    fast_res = '0;
    fast_err = 1'b0;
    case (bus.op_i)
      OP_ADD, OP_ADDI:   fast_res = a + b;
      OP_SUB:            fast_res = a - b;
      OP_SLL, OP_SLLI:   fast_res = a << shamt;
      OP_SRL, OP_SRLI:   fast_res = a >> shamt;
      OP_SRA, OP_SRAI:   fast_res = $signed(a) >>> shamt;
      OP_XOR, OP_XORI:   fast_res = a ^ b;
      OP_OR, OP_ORI:     fast_res = a | b;
      OP_AND, OP_ANDI:   fast_res = a & b;
      OP_SLT, OP_SLTI:   fast_res = XLEN'($signed(a) < $signed(b));
      OP_SLTU, OP_SLTIU: fast_res = XLEN'(a < b);
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:
        fast_res = (b == '0) ? (div_rem ? a : '1) : (div_rem ? '0 : MIN_INT);
      default:           fast_err = 1'b1;
    endcase
  end

  assign out_free = ~out_valid_q | bus.out_ready_i;

  // FSM outputs / handshake controls; flush masks every load.
  always_comb begin
    in_ready_c = (state_q == S_IDLE) & out_free;
    accept     = bus.in_valid_i & in_ready_c & ~flush_i;
    load_fast  = accept & (~is_div | div_special);
    div_start  = accept & is_div & ~div_special;
    div_done   = ~flush_i & out_free &
                 (((state_q == S_DIV_RUN) & (cnt_q == '0)) | (state_q == S_DIV_WAIT));
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (div_start) state_d = S_DIV_RUN;
        S_DIV_RUN:  if (cnt_q == '0) state_d = out_free ? S_IDLE : S_DIV_WAIT;
        S_DIV_WAIT: if (out_free) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // One cycle of restoring division: DIV_RADIX_W shift/compare/subtract steps.
  always_comb begin
    rem_ext  = '0;
    step_rem = rem_q;
    step_quo = quo_q;
    for (int unsigned i = 0; i < DIV_RADIX_W; i++) begin
      rem_ext = {step_rem, step_quo[XLEN-1]};
      if (rem_ext >= {1'b0, dvs_q}) begin
        step_rem = XLEN'(rem_ext - {1'b0, dvs_q});
        step_quo = {step_quo[XLEN-2:0], 1'b1};
      end else begin
        step_rem = rem_ext[XLEN-1:0];
        step_quo = {step_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fixup; a parked result is already fully iterated in the registers.
  always_comb begin
    fin_quo = (state_q == S_DIV_WAIT) ? quo_q : step_quo;
    fin_rem = (state_q == S_DIV_WAIT) ? rem_q : step_rem;
    if (neg_quo_q) fin_quo = -fin_quo;
    if (neg_rem_q) fin_rem = -fin_rem;
    div_res = is_rem_q ? fin_rem : fin_quo;
  end

  // Divider registers: quo_q starts as |dividend| and shifts into the quotient.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else if (div_start) begin
      quo_q     <= a_abs;
      rem_q     <= '0;
      dvs_q     <= b_abs;
      cnt_q     <= CNT_W'(DIV_CYC - 1);
      neg_quo_q <= div_signed & (a[XLEN-1] ^ b[XLEN-1]);
      neg_rem_q <= div_signed & a[XLEN-1];
      is_rem_q  <= div_rem;
    end else if (state_q == S_DIV_RUN) begin
      quo_q <= step_quo;
      rem_q <= step_rem;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (load_fast | div_done) begin
      out_valid_q <= 1'b1;
      result_q    <= load_fast ? fast_res : div_res;
      err_q       <= load_fast & fast_err;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready_o  = in_ready_c;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, handshake/flush/reset sequences and
// randomized ops against a plain-arithmetic reference model. Two instances:
// radix 1 (dut) and radix 4 (dut4).
module tb_alu_mc;
  import nyakuo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic flush4;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(32)) bus ();
  alu_mc_if #(.XLEN(32)) bus4 ();

  alu_mc #(.XLEN(32), .DIV_RADIX_W(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus)
  );
  alu_mc #(.XLEN(32), .DIV_RADIX_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush4), .bus(bus4)
  );

  typedef struct {
    instruction  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_err;
    int          lat;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each op straight from its arithmetic definition.
  function automatic void ref_op(input instruction op, input logic [31:0] a, input logic [31:0] b,
                                 input int div_lat, output logic [31:0] r, output logic e,
                                 output int lat);
    logic signed [31:0] sa, sb;
    sa = a; sb = b; r = '0; e = 1'b0; lat = 1;
    case (op)
      OP_ADD, OP_ADDI:   r = a + b;
      OP_SUB:            r = a - b;
      OP_SLL, OP_SLLI:   r = a << b[4:0];
      OP_SRL, OP_SRLI:   r = a >> b[4:0];
      OP_SRA, OP_SRAI:   r = sa >>> b[4:0];
      OP_XOR, OP_XORI:   r = a ^ b;
      OP_OR, OP_ORI:     r = a | b;
      OP_AND, OP_ANDI:   r = a & b;
      OP_SLT, OP_SLTI:   r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: r = (a < b) ? 32'd1 : 32'd0;
      OP_DIV, OP_REM: begin
        if (b == 32'd0) r = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = (op == OP_DIV) ? a : 32'd0;
        else begin
          r = (op == OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
          lat = div_lat;
        end
      end
      OP_DIVU, OP_REMU: begin
        if (b == 32'd0) r = (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
        else begin
          r = (op == OP_DIVU) ? a / b : a % b;
          lat = div_lat;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on dut, then check result, err, latency and busy in_ready.
  task automatic run_op(input instruction op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e, input int exp_lat,
                        input string name);
    int lat;
    int viol;
    bus.op_i = op; bus.operand_a_i = a; bus.operand_b_i = b;
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 100 && !bus.in_ready_o; i++) begin @(posedge clk); #1; end
    check({name, " in_ready"}, 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 1; viol = 0;
    while (!bus.out_valid_o && lat < 200) begin
      if (bus.in_ready_o) viol++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, bus.result_o, exp_r);
    check({name, " err"}, 32'(bus.err_o), 32'(exp_e));
    if (exp_lat > 1) check({name, " busy_ready_cycles"}, 32'(viol), 32'd0);
  endtask

  // Same as run_op on the radix-4 instance.
  task automatic run_op4(input instruction op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat, input string name);
    int lat;
    bus4.op_i = op; bus4.operand_a_i = a; bus4.operand_b_i = b;
    bus4.in_valid_i = 1'b1; bus4.out_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 100 && !bus4.in_ready_o; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus4.in_valid_i = 1'b0;
    lat = 1;
    while (!bus4.out_valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, bus4.result_o, exp_r);
  endtask

  // Issue a divide on dut and leave it running; returns in DIV_RUN cycle 10.
  task automatic start_div_to_cycle10();
    bus.op_i = OP_DIV; bus.operand_a_i = 32'd1000; bus.operand_b_i = 32'd7;
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    logic        e;
    int          l;
    int          bad;
    int          seen;
    logic [31:0] exp_q[$];
    instruction  op;
    logic [31:0] a, b;

    vecs.push_back('{OP_XOR,  32'hF0F0_0000, 32'h0FF0_FFFF, 32'hFF00_FFFF, 1'b0, 1,  "xor"});
    vecs.push_back('{OP_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1,  "sra"});
    vecs.push_back('{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1,  "sltu"});
    vecs.push_back('{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1,  "slt"});
    vecs.push_back('{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1,  "sub"});
    vecs.push_back('{OP_MUL,  32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1,  "unsupported"});
    vecs.push_back('{OP_ADDI, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1,  "addi_wrap"});
    vecs.push_back('{OP_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1,  "sll31"});
    vecs.push_back('{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1,  "srl31"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33, "div_m7_2"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33, "rem_m7_2"});
    vecs.push_back('{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, "div_7_m2"});
    vecs.push_back('{OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, "rem_7_m2"});
    vecs.push_back('{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33, "divu_100_7"});
    vecs.push_back('{OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 33, "remu_100_7"});
    vecs.push_back('{OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1,  "divu_by0"});
    vecs.push_back('{OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1,  "remu_by0"});
    vecs.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1,  "div_ovf"});
    vecs.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1,  "rem_ovf"});
    vecs.push_back('{OP_DIV,  32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0, 33, "div_min_2"});

    rst_n = 1'b0; flush = 1'b0; flush4 = 1'b0;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1; bus.op_i = OP_ADD;
    bus.operand_a_i = '0; bus.operand_b_i = '0;
    bus4.in_valid_i = 1'b0; bus4.out_ready_i = 1'b1; bus4.op_i = OP_ADD;
    bus4.operand_a_i = '0; bus4.operand_b_i = '0;

    // Reset state.
    #12;
    check("reset out_valid", 32'(bus.out_valid_o), 32'd0);
    check("reset result", bus.result_o, 32'd0);
    check("reset err", 32'(bus.err_o), 32'd0);
    check("reset in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table.
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].exp_err, vecs[i].lat,
             vecs[i].name);

    // Radix-4 instance.
    run_op4(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 9, "r4 div_m7_2");
    run_op4(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 9, "r4 rem_m7_2");
    run_op4(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "r4 divu_by0");

    // Output held while the consumer stalls.
    bus.op_i = OP_ADD; bus.operand_a_i = 32'h1234_0000; bus.operand_b_i = 32'h0000_5678;
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!bus.out_valid_o || bus.result_o !== 32'h1234_5678 || bus.in_ready_o) bad++;
      @(posedge clk); #1;
    end
    check("stall result", bus.result_o, 32'h1234_5678);
    check("stall hold_violations", 32'(bad), 32'd0);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall drained out_valid", 32'(bus.out_valid_o), 32'd0);

    // 100 back-to-back ADDs.
    bad = 0;
    bus.op_i = OP_ADD; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom;
      bus.operand_a_i = a; bus.operand_b_i = b;
      exp_q.push_back(a + b);
      @(posedge clk); #1;
      if (!bus.out_valid_o || bus.result_o !== exp_q.pop_front()) bad++;
    end
    bus.in_valid_i = 1'b0;
    check("back_to_back bad_cycles", 32'(bad), 32'd0);

    // Reset in divide cycle 10.
    start_div_to_cycle10();
    check("pre_reset in_ready", 32'(bus.in_ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_reset in_ready", 32'(bus.in_ready_o), 32'd1);
    check("mid_reset out_valid", 32'(bus.out_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid_o) seen++; end
    check("after_reset stale_valid", 32'(seen), 32'd0);
    run_op(OP_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1, "after_reset add");

    // Flush in divide cycle 10.
    start_div_to_cycle10();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", 32'(bus.in_ready_o), 32'd1);
    check("flush out_valid", 32'(bus.out_valid_o), 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid_o) seen++; end
    check("after_flush stale_valid", 32'(seen), 32'd0);

    // Flush beats both a pending result and a same-cycle accept.
    bus.op_i = OP_ADD; bus.operand_a_i = 32'd1; bus.operand_b_i = 32'd1;
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid_i = 1'b0;
    check("flush_vs_accept out_valid", 32'(bus.out_valid_o), 32'd0);
    @(posedge clk); #1;
    check("flush_vs_accept dropped", 32'(bus.out_valid_o), 32'd0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 200; n++) begin
      op = instruction'(5'($urandom_range(0, 23)));
      a = rand_operand(); b = rand_operand();
      ref_op(op, a, b, 33, r, e, l);
      run_op(op, a, b, r, e, l, $sformatf("rnd%0d %s a=%h b=%h", n, op.name(), a, b));
    end
    for (int n = 0; n < 60; n++) begin
      op = instruction'(5'($urandom_range(19, 22)));
      a = rand_operand(); b = rand_operand();
      ref_op(op, a, b, 9, r, e, l);
      run_op4(op, a, b, r, l, $sformatf("r4rnd%0d %s a=%h b=%h", n, op.name(), a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
